fastram_dram_scheduler: RTL and testbench

Sequences the 8MB FastRAM DRAM array and shares it between 68000 bus accesses and periodic CAS-before-RAS refresh. Replaces free-running refresh with a timer-driven, deferrable refresh queue so refresh never collides with a CPU access. It sits between the autoconfig address decoder (which supplies the access request) and the RAS/CAS/row-column mux drivers.

---
 rtl/fastram_pkg.sv | 11 +
 rtl/fastram_refresh_timer.sv | 33 +++
 rtl/fastram_dram_scheduler.sv | 80 ++++++++
 tb/tb_fastram_dram_scheduler.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fastram_pkg.sv
// fastram_pkg: shared state encoding, refresh timing constant and width helper for the FastRAM scheduler
package fastram_pkg;
   typedef enum logic [2:0] {IDLE, ACC_ROW, ACC_COL, ACC_HOLD, REF_CAS, REF_RAS, REF_END, PRECH} state_t;
   localparam int REF_RAS_CYCLES = 2;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/fastram_refresh_timer.sv
// fastram_refresh_timer: refresh interval timer feeding a saturating deferred-refresh counter
//   CLK, RESETn  clock, async active-low reset
//   tick_clr     a refresh is being started this cycle (consume one pending)
//   ref_pending  deferred refresh count; ref_full = count at MAX_PENDING
module fastram_refresh_timer
   import fastram_pkg::*;
#(
   parameter int REFRESH_INTERVAL = 108,
   parameter int MAX_PENDING = 4,
   localparam int PW = clog2(MAX_PENDING + 1)
) (
   input  logic          CLK,
   input  logic          RESETn,
   input  logic          tick_clr,
   output logic [PW-1:0] ref_pending,
   output logic          ref_full
);
   localparam int TW = clog2(REFRESH_INTERVAL);
   logic [TW-1:0] timer;
   logic tick;
   assign tick = timer == '0;
   assign ref_full = ref_pending == PW'(MAX_PENDING);
   // a tick coinciding with a refresh start cancels out; a tick at saturation is dropped
   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn) begin
         timer <= TW'(REFRESH_INTERVAL - 1);
         ref_pending <= '0;
      end else begin
         timer <= tick ? TW'(REFRESH_INTERVAL - 1) : timer - 1'b1;
         if (tick && !tick_clr && !ref_full) ref_pending <= ref_pending + 1'b1;
         else if (tick_clr && !tick) ref_pending <= ref_pending - 1'b1;
      end
endmodule

// File: rtl/fastram_dram_scheduler.sv
// fastram_dram_scheduler: shares the FastRAM DRAM between 68000 accesses and deferrable CBR refresh
//   CLK, RESETn                 clock, async active-low reset
//   acc_req/ube/lbe/wr          decoded access request, byte enables, write
//   ras, ucas, lcas, col_sel    active-high DRAM strobes and row/column mux select
//   mem_we, acc_ack, busy       write enable, data phase valid, scheduler not idle
//   ref_pending                 deferred refresh count
module fastram_dram_scheduler
   import fastram_pkg::*;
#(
   parameter int REFRESH_INTERVAL = 108,
   parameter int MAX_PENDING = 4,
   parameter int PRECHARGE_CYCLES = 1,
   localparam int PW = clog2(MAX_PENDING + 1)
) (
   input  logic          CLK,
   input  logic          RESETn,
   input  logic          acc_req,
   input  logic          acc_ube,
   input  logic          acc_lbe,
   input  logic          acc_wr,
   output logic          ras,
   output logic          ucas,
   output logic          lcas,
   output logic          col_sel,
   output logic          mem_we,
   output logic          acc_ack,
   output logic          busy,
   output logic [PW-1:0] ref_pending
);
   state_t state, nxt;
   logic [1:0] cnt;
   logic ref_full, ref_go, acc, refc;
   fastram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL), .MAX_PENDING(MAX_PENDING)) u_timer (
      .CLK(CLK),
      .RESETn(RESETn),
      .tick_clr(ref_go),
      .ref_pending(ref_pending),
      .ref_full(ref_full)
   );
   // a full queue outranks the CPU; otherwise the CPU outranks deferred refresh
   always_comb begin
      nxt = state;
      case (state)
         IDLE:              nxt = ref_full ? REF_CAS : acc_req ? ACC_ROW : ref_pending != '0 ? REF_CAS : IDLE;
         ACC_ROW:           nxt = acc_req ? ACC_COL : PRECH;
         ACC_COL, ACC_HOLD: nxt = acc_req ? ACC_HOLD : PRECH;
         REF_CAS:           nxt = REF_RAS;
         REF_RAS:           nxt = cnt == '0 ? REF_END : REF_RAS;
         REF_END:           nxt = PRECH;
         PRECH:             nxt = cnt == '0 ? IDLE : PRECH;
         default:           nxt = IDLE;
      endcase
   end
   assign ref_go = state == IDLE && nxt == REF_CAS;
   assign acc = nxt == ACC_COL || nxt == ACC_HOLD;
   assign refc = nxt == REF_CAS || nxt == REF_RAS;
   // outputs are registered from the next state so they line up with the state register
   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn) begin
         state <= IDLE;
         cnt <= '0;
         ras <= 1'b0;
         ucas <= 1'b0;
         lcas <= 1'b0;
         col_sel <= 1'b0;
         mem_we <= 1'b0;
         acc_ack <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= nxt;
         cnt <= nxt != state ? (nxt == REF_RAS ? 2'(REF_RAS_CYCLES - 1) : 2'(PRECHARGE_CYCLES - 1)) : cnt - 1'b1;
         ras <= nxt == ACC_ROW || acc || nxt == REF_RAS || nxt == REF_END;
         ucas <= acc ? acc_ube : refc;
         lcas <= acc ? acc_lbe : refc;
         col_sel <= acc;
         mem_we <= acc && acc_wr;
         acc_ack <= nxt == ACC_HOLD;
         busy <= nxt != IDLE;
      end
endmodule

// File: tb/tb_fastram_dram_scheduler.sv
// tb_fastram_dram_scheduler: directed self-checking bench for the FastRAM scheduler
module tb_fastram_dram_scheduler;
   localparam logic [15:0] O_IDLE   = 16'h0000;
   localparam logic [15:0] O_PRE    = 16'h0001;
   localparam logic [15:0] O_RCAS   = 16'h0031;
   localparam logic [15:0] O_RRAS   = 16'h0071;
   localparam logic [15:0] O_REND   = 16'h0041;
   localparam logic [15:0] O_ROW    = 16'h0041;
   localparam logic [15:0] O_RDCOL  = 16'h0079;
   localparam logic [15:0] O_RDHOLD = 16'h007B;
   localparam logic [15:0] O_WRCOL  = 16'h005D;
   localparam logic [15:0] O_WRHOLD = 16'h005F;
   localparam logic [15:0] O_WRUB   = 16'h007F;
   logic CLK = 1'b0;
   logic RESETn, acc_req, acc_ube, acc_lbe, acc_wr;
   logic ras, ucas, lcas, col_sel, mem_we, acc_ack, busy;
   logic [2:0] ref_pending;
   logic [15:0] o, pend, maxp, nref;
   logic p_ras = 1'b0, p_cas = 1'b0, p_col = 1'b0;
   logic bad_acc, bad_ref, bad_we, bad_col;
   int checks = 0, failures = 0, inv_err = 0;
   fastram_dram_scheduler #(.REFRESH_INTERVAL(108), .MAX_PENDING(4), .PRECHARGE_CYCLES(1)) dut (
      .CLK(CLK),
      .RESETn(RESETn),
      .acc_req(acc_req),
      .acc_ube(acc_ube),
      .acc_lbe(acc_lbe),
      .acc_wr(acc_wr),
      .ras(ras),
      .ucas(ucas),
      .lcas(lcas),
      .col_sel(col_sel),
      .mem_we(mem_we),
      .acc_ack(acc_ack),
      .busy(busy),
      .ref_pending(ref_pending)
   );
   always #5 CLK = ~CLK;
   assign o = {9'b0, ras, ucas, lcas, col_sel, mem_we, acc_ack, busy};
   assign pend = {13'b0, ref_pending};
   assign bad_acc = (ucas | lcas) && col_sel && !(ras && p_ras);
   assign bad_ref = ras && !p_ras && (ucas | lcas) && !p_cas;
   assign bad_we = mem_we && !col_sel;
   assign bad_col = col_sel != p_col && (ucas | lcas) && p_cas;
   always @(negedge CLK) begin
      if (RESETn && (bad_acc || bad_ref || bad_we || bad_col)) inv_err <= inv_err + 1;
      p_ras <= ras;
      p_cas <= ucas | lcas;
      p_col <= col_sel;
   end
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask
   initial begin
      RESETn = 1'b0;
      acc_req = 1'b0;
      acc_ube = 1'b0;
      acc_lbe = 1'b0;
      acc_wr = 1'b0;
      step(3);
      chk("rst_out", o, O_IDLE);
      chk("rst_pend", pend, 16'd0);
      RESETn = 1'b1;
      step(107);
      chk("pend_107", pend, 16'd0);
      step(1);
      chk("pend_108", pend, 16'd1);
      chk("idle_108", o, O_IDLE);
      step(1);
      chk("ref_cas", o, O_RCAS);
      chk("pend_109", pend, 16'd0);
      step(1);
      chk("ref_ras1", o, O_RRAS);
      step(1);
      chk("ref_ras2", o, O_RRAS);
      step(1);
      chk("ref_end", o, O_REND);
      step(1);
      chk("ref_prech", o, O_PRE);
      step(1);
      chk("ref_idle", o, O_IDLE);
      acc_req = 1'b1;
      acc_ube = 1'b1;
      acc_lbe = 1'b1;
      step(1);
      chk("rd_row", o, O_ROW);
      step(1);
      chk("rd_col", o, O_RDCOL);
      step(1);
      chk("rd_hold", o, O_RDHOLD);
      acc_req = 1'b0;
      step(1);
      chk("rd_prech", o, O_PRE);
      step(1);
      chk("rd_idle", o, O_IDLE);
      acc_req = 1'b1;
      acc_ube = 1'b0;
      acc_lbe = 1'b1;
      acc_wr = 1'b1;
      step(1);
      chk("wr_row", o, O_ROW);
      step(1);
      chk("wr_col", o, O_WRCOL);
      step(1);
      chk("wr_hold", o, O_WRHOLD);
      acc_ube = 1'b1;
      step(1);
      chk("wr_late_ube", o, O_WRUB);
      acc_req = 1'b0;
      acc_ube = 1'b0;
      acc_lbe = 1'b0;
      acc_wr = 1'b0;
      step(1);
      chk("wr_prech", o, O_PRE);
      step(1);
      chk("wr_idle", o, O_IDLE);
      acc_req = 1'b1;
      acc_ube = 1'b1;
      acc_lbe = 1'b1;
      maxp = '0;
      for (int i = 0; i < 600; i++) begin
         step(1);
         if (pend > maxp) maxp = pend;
      end
      chk("sat_max", maxp, 16'd4);
      chk("sat_pend", pend, 16'd4);
      chk("sat_hold", o, O_RDHOLD);
      acc_req = 1'b0;
      acc_ube = 1'b0;
      acc_lbe = 1'b0;
      nref = '0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (o == O_RCAS) nref = nref + 16'd1;
      end
      chk("drain_count", nref, 16'd4);
      chk("drain_pend", pend, 16'd0);
      chk("drain_idle", o, O_IDLE);
      acc_req = 1'b1;
      acc_ube = 1'b1;
      acc_lbe = 1'b1;
      step(345);
      chk("sat2_pend", pend, 16'd4);
      acc_req = 1'b0;
      step(1);
      chk("sat2_prech", o, O_PRE);
      acc_req = 1'b1;
      step(1);
      chk("coll_idle", o, O_IDLE);
      step(1);
      chk("coll_ref_first", o, O_RCAS);
      chk("coll_pend", pend, 16'd3);
      step(5);
      chk("coll_idle2", o, O_IDLE);
      step(1);
      chk("coll_row", o, O_ROW);
      step(2);
      chk("coll_hold", o, O_RDHOLD);
      #2 RESETn = 1'b0;
      #1;
      chk("arst_out", o, O_IDLE);
      chk("arst_pend", pend, 16'd0);
      acc_req = 1'b0;
      acc_ube = 1'b0;
      acc_lbe = 1'b0;
      @(posedge CLK);
      #1 RESETn = 1'b1;
      step(107);
      chk("post_rst_107", pend, 16'd0);
      step(1);
      chk("post_rst_108", pend, 16'd1);
      chk("invariants", 16'(inv_err), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
